// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, default opcode
// width and the controller state type.
package alu_pkg;

    localparam int unsigned OPW_DEF = 4;

    // Opcodes 0-7 keep the encoding of the original 3-bit ALU.
    localparam int unsigned OP_HLT = 0;
    localparam int unsigned OP_SKZ = 1;
    localparam int unsigned OP_ADD = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_LDA = 5;
    localparam int unsigned OP_STO = 6;
    localparam int unsigned OP_JMP = 7;
    localparam int unsigned OP_SUB = 8;
    localparam int unsigned OP_SHL = 9;
    localparam int unsigned OP_SHR = 10;
    localparam int unsigned OP_MUL = 11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the controller (master) and the ALU (slave).
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = OPW_DEF
);

    logic             start;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, opcode, data, accum,
        input  alu_out, carry, zero, busy, done, err
    );

    modport slave (
        input  start, opcode, data, accum,
        output alu_out, carry, zero, busy, done, err
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, LSB first.
// 'product' is the accumulated value including the step being taken this
// cycle, so the owner can register the final result on the last step.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               alu_clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = (cnt_q == CW'(WIDTH - 1));

    // Operand capture on load, one partial-product accumulation per step.
    always_ff @(posedge alu_clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
            mplier_q <= mplier_in;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops complete
// one cycle after start; MUL runs WIDTH iterations in alu_mul_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = OPW_DEF
) (
    input logic      alu_clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    alu_state_t         state;
    alu_state_t         state_nxt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH-1:0]   op_val;
    logic               op_carry;
    logic               op_err;
    logic               is_mul;

    logic               mul_load;
    logic               mul_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    logic               res_we;
    logic [WIDTH-1:0]   res_val;
    logic               res_carry;
    logic               res_err;

    logic [WIDTH-1:0]   alu_out_q;
    logic               carry_q;
    logic               err_q;
    logic               done_q;

    assign is_mul      = (bus.opcode == OPW'(OP_MUL));
    assign bus.zero    = (bus.accum == '0);
    assign bus.busy    = (state == ST_MUL_RUN);
    assign bus.alu_out = alu_out_q;
    assign bus.carry   = carry_q;
    assign bus.err     = err_q;
    assign bus.done    = done_q;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .alu_clk  (alu_clk),
        .rst      (rst),
        .load     (mul_load),
        .step     (mul_step),
        .mcand_in (bus.accum),
        .mplier_in(bus.data),
        .product  (mul_prod),
        .last     (mul_last)
    );

    // Single-cycle result and flag selection from the live operands.
    always_comb begin
        add_sum  = {1'b0, bus.accum} + {1'b0, bus.data};
        sub_diff = {1'b0, bus.accum} - {1'b0, bus.data};
        op_val   = '0;
        op_carry = 1'b0;
        op_err   = 1'b0;
        case (bus.opcode)
            OPW'(OP_HLT), OPW'(OP_SKZ), OPW'(OP_STO), OPW'(OP_JMP): begin
                op_val = bus.accum;
            end
            OPW'(OP_ADD): begin
                op_val   = add_sum[WIDTH-1:0];
                op_carry = add_sum[WIDTH];
            end
            OPW'(OP_AND): op_val = bus.accum & bus.data;
            OPW'(OP_XOR): op_val = bus.accum ^ bus.data;
            OPW'(OP_LDA): op_val = bus.data;
            OPW'(OP_SUB): begin
                op_val   = sub_diff[WIDTH-1:0];
                op_carry = sub_diff[WIDTH];
            end
            OPW'(OP_SHL): begin
                op_val   = {bus.accum[WIDTH-2:0], 1'b0};
                op_carry = bus.accum[WIDTH-1];
            end
            OPW'(OP_SHR): begin
                op_val   = {1'b0, bus.accum[WIDTH-1:1]};
                op_carry = bus.accum[0];
            end
            OPW'(OP_MUL): op_val = '0;
            default:      op_err = 1'b1;
        endcase
    end

    // Controller state register.
    always_ff @(posedge alu_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, multiplier control and result-write selection.
    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        res_we    = 1'b0;
        res_val   = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        mul_load  = 1'b1;
                        state_nxt = ST_MUL_RUN;
                    end else begin
                        res_we    = 1'b1;
                        res_val   = op_val;
                        res_carry = op_carry;
                        res_err   = op_err;
                    end
                end
            end
            ST_MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_we    = 1'b1;
                    res_val   = mul_prod[WIDTH-1:0];
                    res_carry = |mul_prod[2*WIDTH-1:WIDTH];
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result registers: updated only on completion, done pulses for one cycle.
    always_ff @(posedge alu_clk) begin
        if (rst) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= res_we;
            if (res_we) begin
                alu_out_q <= res_val;
                carry_q   <= res_carry;
                err_q     <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_seq;

    localparam int W     = 8;
    localparam int OW    = 4;
    localparam int MULOP = 11;

    typedef struct {
        int           op;
        logic [W-1:0] d;
        logic [W-1:0] a;
        logic [W-1:0] eo;
        logic         ec;
        logic         ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_seq_if #(.WIDTH(W), .OPW(OW)) bus ();

    alu_seq #(
        .WIDTH(W),
        .OPW  (OW)
    ) dut (
        .alu_clk(clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result of one operation, from the arithmetic definitions.
    function automatic void model(input int op, input longint a, input longint d,
                                  output longint r, output bit c, output bit e);
        longint md;
        longint t;
        md = longint'(1) << W;
        r  = 0;
        c  = 1'b0;
        e  = 1'b0;
        case (op)
            0, 1, 6, 7: r = a;
            2:  begin t = a + d; r = t % md; c = (t >= md); end
            3:  r = a & d;
            4:  r = a ^ d;
            5:  r = d;
            8:  begin r = (a - d + md) % md; c = (a < d); end
            9:  begin r = (a * 2) % md; c = (a >= md / 2); end
            10: begin r = a / 2; c = (a % 2 == 1); end
            11: begin t = a * d; r = t % md; c = (t >= md); end
            default: e = 1'b1;
        endcase
    endfunction

    // Model state: expectations for the current cycle.
    bit           m_valid = 1'b0;
    int           m_left  = 0;
    bit           m_done  = 1'b0;
    logic [W-1:0] m_out;
    bit           m_c, m_e;
    logic [W-1:0] p_out;
    bit           p_c, p_e;

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        longint r;
        bit     c, e;
        if (m_valid) begin
            chk("busy", bus.busy, (m_left > 0));
            chk("done", bus.done, m_done);
            chk("alu_out", bus.alu_out, m_out);
            chk("carry", bus.carry, m_c);
            chk("err", bus.err, m_e);
            chk("zero", bus.zero, (bus.accum == 0));
        end
        if (rst === 1'b1) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_out   = '0;
            m_c     = 1'b0;
            m_e     = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_out  = p_out;
                    m_c    = p_c;
                    m_e    = p_e;
                end
            end else if (bus.start === 1'b1) begin
                model(int'(bus.opcode), longint'(bus.accum), longint'(bus.data), r, c, e);
                if (int'(bus.opcode) == MULOP) begin
                    m_left = W;
                    p_out  = r[W-1:0];
                    p_c    = c;
                    p_e    = e;
                end else begin
                    m_done = 1'b1;
                    m_out  = r[W-1:0];
                    m_c    = c;
                    m_e    = e;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start, then disturb the operands.
    task automatic start_op(input int op, input logic [W-1:0] d, input logic [W-1:0] a);
        bus.opcode = OW'(op);
        bus.data   = d;
        bus.accum  = a;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.data   = ~d;
        bus.accum  = ~a;
    endtask

    // Bounded wait for done; checks latency, busy cycles and result.
    task automatic wait_done(input string name, input int lat, input int bexp,
                             input logic [W-1:0] eo, input logic ec, input logic ee);
        int k  = 0;
        int bc = 0;
        bit got = 1'b0;
        while (!got && k < lat + 4) begin
            k++;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.busy === 1'b1) bc++;
                tick();
            end
        end
        chk({name, "_done_seen"}, got, 1);
        if (got) begin
            chk({name, "_latency"}, k, lat);
            chk({name, "_busy_cycles"}, bc, bexp);
            chk({name, "_out"}, bus.alu_out, eo);
            chk({name, "_carry"}, bus.carry, ec);
            chk({name, "_err"}, bus.err, ee);
            tick();
        end
    endtask

    vec_t tbl [12] = '{
        '{2,  8'h01, 8'hFF, 8'h00, 1'b1, 1'b0},
        '{3,  8'h3C, 8'hF0, 8'h30, 1'b0, 1'b0},
        '{4,  8'h3C, 8'hF0, 8'hCC, 1'b0, 1'b0},
        '{0,  8'h11, 8'h77, 8'h77, 1'b0, 1'b0},
        '{7,  8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0},
        '{1,  8'h44, 8'h00, 8'h00, 1'b0, 1'b0},
        '{6,  8'h99, 8'h12, 8'h12, 1'b0, 1'b0},
        '{15, 8'h55, 8'h66, 8'h00, 1'b0, 1'b1},
        '{11, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0},
        '{11, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0},
        '{8,  8'h07, 8'h07, 8'h00, 1'b0, 1'b0},
        '{11, 8'h80, 8'h02, 8'h00, 1'b1, 1'b0}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_done;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.data   = '0;
        bus.accum  = 8'h01;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_alu_out", bus.alu_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_carry", bus.carry, 0);
        tick();

        // ADD with carry out.
        start_op(2, 8'hF0, 8'h20);
        wait_done("add", 1, 0, 8'h10, 1'b1, 1'b0);

        // Reset in the middle of a MUL: aborted, no done.
        start_op(MULOP, 8'h11, 8'h0F);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midmul_rst_out", bus.alu_out, 0);
        chk("midmul_rst_busy", bus.busy, 0);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.done !== 1'b0) saw_done = 1;
            tick();
        end
        chk("midmul_rst_no_done", saw_done, 0);

        // SUB borrow, SHL and SHR shift-out.
        start_op(8, 8'h07, 8'h05);
        wait_done("sub", 1, 0, 8'hFE, 1'b1, 1'b0);
        start_op(9, 8'h00, 8'h81);
        wait_done("shl", 1, 0, 8'h02, 1'b1, 1'b0);
        start_op(10, 8'h00, 8'h01);
        wait_done("shr", 1, 0, 8'h00, 1'b1, 1'b0);

        // MUL without and with high-half overflow; starts while busy ignored.
        start_op(MULOP, 8'h11, 8'h0F);
        wait_done("mul_ff", W + 1, W, 8'hFF, 1'b0, 1'b0);
        start_op(MULOP, 8'h10, 8'h10);
        for (int i = 0; i < 3; i++) begin
            bus.opcode = OW'(2);
            bus.data   = 8'h01;
            bus.accum  = 8'h01;
            bus.start  = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        wait_done("mul_ovf", W + 1 - 3, W - 3, 8'h00, 1'b1, 1'b0);

        // Illegal op, then a legal LDA clears err.
        start_op(12, 8'h33, 8'h44);
        wait_done("illegal", 1, 0, 8'h00, 1'b0, 1'b1);
        start_op(5, 8'h5A, 8'h00);
        wait_done("lda", 1, 0, 8'h5A, 1'b0, 1'b0);

        // zero follows accum with no start.
        bus.accum = '0;
        @(negedge clk);
        chk("zero_set", bus.zero, 1);
        bus.accum = 8'h33;
        #1;
        chk("zero_clr", bus.zero, 0);
        tick();

        // Back-to-back: second start on the done cycle of the first.
        start_op(2, 8'h01, 8'h02);
        bus.opcode = OW'(2);
        bus.data   = 8'hFF;
        bus.accum  = 8'hFF;
        bus.start  = 1'b1;
        @(negedge clk);
        chk("b2b_first_done", bus.done, 1);
        chk("b2b_first_out", bus.alu_out, 8'h03);
        tick();
        bus.start = 1'b0;
        wait_done("b2b_second", 1, 0, 8'hFE, 1'b1, 1'b0);

        // Remaining ops and boundaries.
        foreach (tbl[i]) begin
            start_op(tbl[i].op, tbl[i].d, tbl[i].a);
            wait_done($sformatf("vec%0d_op%0d", i, tbl[i].op),
                      (tbl[i].op == MULOP) ? W + 1 : 1,
                      (tbl[i].op == MULOP) ? W : 0,
                      tbl[i].eo, tbl[i].ec, tbl[i].ee);
        end

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
